// File: rtl/cic_pkg.sv
// Shared definitions for the CIC run-time controller: FSM encoding, ratio limits
// and the ratio range check.
package cic_pkg;

  localparam int unsigned MIN_RATIO     = 2;
  localparam int unsigned MAX_RATIO     = 1024;
  localparam int unsigned DEFAULT_RATIO = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESET  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } cic_state_e;

  function automatic logic ratio_legal(input logic [31:0] r,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    return (r >= lo) && (r <= hi);
  endfunction

endpackage

// File: rtl/cic_strobe_wd.sv
// Rising-edge detector on the CIC decimated clock plus a saturating watchdog
// that flags 2*ratio consecutive cycles without a strobe.
module cic_strobe_wd #(
  parameter int RATIO_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cic_dclk,
  input  logic               active,
  input  logic               clr,
  input  logic [RATIO_W-1:0] ratio,
  output logic               strb,
  output logic               timeout
);

  localparam logic [RATIO_W+1:0] ONE = (RATIO_W+2)'(1);

  logic               dclk_q;
  logic [RATIO_W+1:0] cnt_q, cnt_d;
  logic [RATIO_W+1:0] lim_m1;

  assign strb   = cic_dclk & ~dclk_q;
  // cnt_q holds the number of strobe-free cycles already completed, so the
  // current cycle is the 2*ratio-th one when cnt_q reaches 2*ratio-1.
  assign lim_m1 = {1'b0, ratio, 1'b0} - ONE;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || strb || !active) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + ONE;
    end
  end

  assign timeout = active & ~strb & ~clr & (cnt_q >= lim_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dclk_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      dclk_q <= cic_dclk;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cic_ctrl.sv
// Run-time controller for the CIC decimator: ratio configuration, CIC reset
// sequencing, settling-sample discard, sample forwarding and stall recovery.
module cic_ctrl #(
  parameter int          DATA_W        = 31,
  parameter int          RATIO_W       = 16,
  parameter int unsigned MIN_RATIO     = cic_pkg::MIN_RATIO,
  parameter int unsigned MAX_RATIO     = cic_pkg::MAX_RATIO,
  parameter int unsigned DEFAULT_RATIO = cic_pkg::DEFAULT_RATIO,
  parameter int          ORDER         = 5,
  parameter int          RST_CYCLES    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cfg_valid,
  input  logic [RATIO_W-1:0] cfg_ratio,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               cic_rst,
  output logic [RATIO_W-1:0] cic_ratio,
  input  logic [DATA_W-1:0]  cic_dout,
  input  logic               cic_dclk,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               stall
);
  import cic_pkg::*;

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int SET_W = $clog2(ORDER + 1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(ORDER - 1);

  cic_state_e         state_q, state_d, prev_q;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic               stall_q, stall_d;
  logic               err_q, err_d;
  logic               ovld_q, ovld_d;
  logic [DATA_W-1:0]  odata_q, odata_d;
  logic               xfer, legal, strb, timeout, wd_active, wd_clr;

  assign cfg_ready = (state_q != ST_RESET);
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = xfer & ratio_legal(32'(cfg_ratio), MIN_RATIO, MAX_RATIO);
  assign wd_active = (state_q == ST_SETTLE) || (state_q == ST_RUN);
  // Registered entry flag keeps the watchdog clear off the next-state path.
  assign wd_clr    = (state_q != prev_q);

  cic_strobe_wd #(.RATIO_W(RATIO_W)) u_strobe_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .cic_dclk (cic_dclk),
    .active   (wd_active),
    .clr      (wd_clr),
    .ratio    (ratio_q),
    .strb     (strb),
    .timeout  (timeout)
  );

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    set_cnt_d = set_cnt_q;
    ratio_d   = legal ? cfg_ratio : ratio_q;
    stall_d   = timeout | (stall_q & ~legal);
    err_d     = xfer & ~legal;
    ovld_d    = 1'b0;
    odata_d   = odata_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_RESET;
          rst_cnt_d = RST_LOAD;
        end
      end
      ST_RESET: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (rst_cnt_q == '0) begin
          state_d   = ST_SETTLE;
          set_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_W'(1);
        end
      end
      ST_SETTLE, ST_RUN: begin
        // Disable beats restart, and restart beats any strobe in the same cycle.
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (legal || timeout) begin
          state_d   = ST_RESET;
          rst_cnt_d = RST_LOAD;
        end else if (strb) begin
          if (state_q == ST_RUN) begin
            ovld_d  = 1'b1;
            odata_d = cic_dout;
          end else if (set_cnt_q == SET_LAST) begin
            state_d = ST_RUN;
          end else begin
            set_cnt_d = set_cnt_q + SET_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prev_q    <= ST_IDLE;
      rst_cnt_q <= '0;
      set_cnt_q <= '0;
      ratio_q   <= RATIO_W'(DEFAULT_RATIO);
      stall_q   <= 1'b0;
      err_q     <= 1'b0;
      ovld_q    <= 1'b0;
      odata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= state_q;
      rst_cnt_q <= rst_cnt_d;
      set_cnt_q <= set_cnt_d;
      ratio_q   <= ratio_d;
      stall_q   <= stall_d;
      err_q     <= err_d;
      ovld_q    <= ovld_d;
      odata_q   <= odata_d;
    end
  end

  assign cic_rst   = (state_q == ST_IDLE) || (state_q == ST_RESET);
  assign busy      = (state_q == ST_RESET) || (state_q == ST_SETTLE);
  assign cic_ratio = ratio_q;
  assign cfg_err   = err_q;
  assign out_valid = ovld_q;
  assign out_data  = odata_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_cic_ctrl.sv
// Scoreboard bench for cic_ctrl: forwarded samples are queued when the strobe
// is driven and popped when out_valid appears.
module tb_cic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_ratio = '0;
  logic        cfg_ready, cfg_err, cic_rst, out_valid, busy, stall;
  logic [15:0] cic_ratio;
  logic [30:0] cic_dout = '0;
  logic        cic_dclk = 1'b0;
  logic [30:0] out_data;

  int n_chk = 0;
  int n_err = 0;
  logic [30:0] exp_q[$];

  cic_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cic_rst   (cic_rst),
    .cic_ratio (cic_ratio),
    .cic_dout  (cic_dout),
    .cic_dclk  (cic_dclk),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [30:0] e;
    if (rst_n && out_valid) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [30:0] d, input bit fwd, input int gap);
    cic_dout = d;
    cic_dclk = 1'b1;
    if (fwd) exp_q.push_back(d);
    @(posedge clk);
    #1 cic_dclk = 1'b0;
    @(negedge clk);
    chk("ovld_latency", 64'(out_valid), 64'(fwd));
    repeat (gap) tick();
  endtask

  task automatic cfg_send(input logic [15:0] r);
    int n = 0;
    cfg_ratio = r;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("cfg_ready_wait", 64'(cfg_ready), 64'(1));
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic reset_len(output int n);
    n = 0;
    while (busy && cic_rst && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 5; i++) pulse(31'($urandom), 1'b0, 3);
    chk("run_busy", 64'(busy), 64'(0));
    chk("run_cic_rst", 64'(cic_rst), 64'(0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cic_rst"}, 64'(cic_rst), 64'(1));
    chk({tag, "_ratio"}, 64'(cic_ratio), 64'(64));
    chk({tag, "_ready"}, 64'(cfg_ready), 64'(1));
    chk({tag, "_err"}, 64'(cfg_err), 64'(0));
    chk({tag, "_ovld"}, 64'(out_valid), 64'(0));
    chk({tag, "_odata"}, 64'(out_data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_stall"}, 64'(stall), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");

    // Test 1: power-up start
    tick();
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    reset_len(n);
    chk("t1_rst_len", 64'(n), 64'(4));
    chk("t1_ratio", 64'(cic_ratio), 64'(64));
    settle();
    for (int i = 0; i < 3; i++) pulse(31'($urandom), 1'b1, 3);

    // Test 3: illegal ratios on both sides of the range
    cfg_send(16'd1);
    chk("t3_err_lo", 64'(cfg_err), 64'(1));
    chk("t3_ratio_lo", 64'(cic_ratio), 64'(64));
    chk("t3_busy_lo", 64'(busy), 64'(0));
    tick();
    chk("t3_err_pulse", 64'(cfg_err), 64'(0));
    pulse(31'($urandom), 1'b1, 3);
    cfg_send(16'd2000);
    chk("t3_err_hi", 64'(cfg_err), 64'(1));
    chk("t3_ratio_hi", 64'(cic_ratio), 64'(64));
    tick();
    chk("t3_err_pulse2", 64'(cfg_err), 64'(0));
    pulse(31'($urandom), 1'b1, 3);

    // Test 2: reconfigure while running
    cfg_send(16'd32);
    chk("t2_ratio", 64'(cic_ratio), 64'(32));
    chk("t2_cic_rst", 64'(cic_rst), 64'(1));
    chk("t2_busy", 64'(busy), 64'(1));
    chk("t2_err", 64'(cfg_err), 64'(0));
    reset_len(n);
    chk("t2_rst_len", 64'(n), 64'(4));
    for (int i = 0; i < 5; i++) begin
      pulse(31'($urandom), 1'b0, 3);
      if (i < 4) chk("t2_busy_settle", 64'(busy), 64'(1));
    end
    chk("t2_run", 64'(busy), 64'(0));
    for (int i = 0; i < 3; i++) pulse(31'($urandom), 1'b1, 3);

    // Test 4: request during RESET waits for SETTLE
    cfg_send(16'd40);
    cfg_ratio = 16'd48;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      chk("t4_ratio_hold", 64'(cic_ratio), 64'(40));
      tick();
      n++;
    end
    chk("t4_not_ready_len", 64'(n), 64'(4));
    chk("t4_settle", 64'(busy & ~cic_rst), 64'(1));
    tick();
    cfg_valid = 1'b0;
    chk("t4_ratio", 64'(cic_ratio), 64'(48));
    reset_len(n);
    chk("t4_rst_len", 64'(n), 64'(4));
    settle();
    pulse(31'($urandom), 1'b1, 3);

    // Test 5: frozen strobe at ratio 64
    cfg_send(16'd64);
    reset_len(n);
    settle();
    pulse(31'($urandom), 1'b1, 1);
    n = 1;
    while (!stall && n < 300) begin
      tick();
      n++;
    end
    chk("t5_wd_cycles", 64'(n), 64'(128));
    chk("t5_reset", 64'(busy & cic_rst), 64'(1));
    cfg_send(16'd64);
    chk("t5_stall_clr", 64'(stall), 64'(0));
    chk("t5_restart", 64'(cic_rst), 64'(1));
    reset_len(n);
    settle();
    pulse(31'($urandom), 1'b1, 3);

    // Test 6: disable + strobe + legal cfg in the same SETTLE cycle
    cfg_send(16'd64);
    reset_len(n);
    pulse(31'($urandom), 1'b0, 3);
    pulse(31'($urandom), 1'b0, 3);
    enable    = 1'b0;
    cfg_ratio = 16'd16;
    cfg_valid = 1'b1;
    cic_dout  = 31'($urandom);
    cic_dclk  = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cic_dclk  = 1'b0;
    chk("t6_cic_rst", 64'(cic_rst), 64'(1));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_ratio", 64'(cic_ratio), 64'(16));
    chk("t6_ovld", 64'(out_valid), 64'(0));
    chk("t6_err", 64'(cfg_err), 64'(0));
    tick();
    chk("t6_ovld2", 64'(out_valid), 64'(0));
    chk("t6_idle", 64'(cic_rst & ~busy), 64'(1));

    cfg_send(16'd1024);
    chk("t6_max_legal", 64'(cic_ratio), 64'(1024));
    chk("t6_max_err", 64'(cfg_err), 64'(0));
    chk("t6_max_idle", 64'(cic_rst & ~busy), 64'(1));
    cfg_send(16'd1025);
    chk("t6_over_err", 64'(cfg_err), 64'(1));
    chk("t6_over_ratio", 64'(cic_ratio), 64'(1024));
    cfg_send(16'd2);
    chk("t6_min_legal", 64'(cic_ratio), 64'(2));
    cfg_send(16'd100);
    chk("t6_ratio100", 64'(cic_ratio), 64'(100));

    enable = 1'b1;
    tick();
    reset_len(n);
    chk("t6_rst_len", 64'(n), 64'(4));
    settle();
    pulse(31'($urandom) | 31'd1, 1'b1, 3);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
